// File: rtl/enemy_sprite_engine.sv
// Enemy sprite engine: spawns one enemy, streams its pixels to the VGA arbiter over a
// valid/ready handshake, holds for a frame delay, erases, moves down (optionally zig-zagging) and repeats.
module enemy_sprite_engine #(
   parameter int SPR_W           = 10,
   parameter int SPR_H           = 10,
   parameter int DELAY_CYCLES    = 833333,
   parameter int FRAMES_PER_STEP = 15,
   parameter int STEP_X          = 1,
   parameter int STEP_Y          = 1,
   parameter int X_MAX           = 159,
   parameter int Y_LIMIT         = 111
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_go,
   input  logic       i_mode,
   input  logic [7:0] i_x_start,
   input  logic [2:0] i_colour_in,
   input  logic       i_kill,
   input  logic       i_pix_ready,
   output logic [7:0] o_x_out,
   output logic [6:0] o_y_out,
   output logic [2:0] o_colour_out,
   output logic       o_plot,
   output logic       o_active,
   output logic       o_escaped,
   output logic       o_killed
);

   localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int FW = $clog2(FRAMES_PER_STEP + 1);
   localparam logic [5:0]    LAST_CX    = 6'(SPR_W - 1);
   localparam logic [5:0]    LAST_CY    = 6'(SPR_H - 1);
   localparam logic [DW-1:0] LAST_DELAY = DW'(DELAY_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_GOAL = FW'(FRAMES_PER_STEP);
   localparam logic [9:0]    X_MAX_W    = 10'(X_MAX);
   localparam logic [9:0]    SPAN_W     = 10'(SPR_W - 1);
   localparam logic [9:0]    STEP_X_W   = 10'(STEP_X);
   localparam logic [7:0]    STEP_X_B   = 8'(STEP_X);
   localparam logic [7:0]    STEP_Y_W   = 8'(STEP_Y);
   localparam logic [7:0]    Y_LIMIT_W  = 8'(Y_LIMIT);
   localparam logic [7:0]    X_CLAMP    = 8'(X_MAX - SPR_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_DRAW, S_HOLD, S_ERASE, S_UPDATE} state_t;

   state_t          r_state, w_stateNext;
   logic [7:0]      r_x, w_x;
   logic [6:0]      r_y, w_y;
   logic            r_dirLeft, w_dirLeft;
   logic            r_mode, w_mode;
   logic [2:0]      r_colour, w_colour;
   logic [5:0]      r_cx, w_cx;
   logic [5:0]      r_cy, w_cy;
   logic [DW-1:0]   r_delayCnt, w_delayCnt;
   logic [FW-1:0]   r_frameCnt, w_frameCnt;
   logic            r_killLatch, w_killLatch;
   logic            w_escaped, w_killed;

   logic [7:0]      r_xOut;
   logic [6:0]      r_yOut;
   logic [2:0]      r_colourOut;
   logic            r_plot, r_active, r_escaped, r_killed;

   logic            w_accept, w_lastPix, w_plotNext;
   logic [7:0]      w_yStep;

   assign w_accept  = ((r_state == S_DRAW) || (r_state == S_ERASE)) && i_pix_ready;
   assign w_lastPix = (r_cx == LAST_CX) && (r_cy == LAST_CY);
   assign w_yStep   = {1'b0, r_y} + STEP_Y_W;

   // Next-state and datapath updates; the scan counter only moves on an accepted pixel.
   always_comb begin
      w_stateNext = r_state;
      w_x         = r_x;
      w_y         = r_y;
      w_dirLeft   = r_dirLeft;
      w_mode      = r_mode;
      w_colour    = r_colour;
      w_cx        = r_cx;
      w_cy        = r_cy;
      w_delayCnt  = r_delayCnt;
      w_frameCnt  = r_frameCnt;
      w_killLatch = r_killLatch;
      w_escaped   = 1'b0;
      w_killed    = 1'b0;

      if (w_accept && !w_lastPix) begin
         if (r_cx == LAST_CX) begin
            w_cx = '0;
            w_cy = r_cy + 6'd1;
         end else begin
            w_cx = r_cx + 6'd1;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (i_go) w_stateNext = S_ARM;
         end
         S_ARM: begin
            if (!i_go) begin
               w_stateNext = S_DRAW;
               w_x         = (({2'b00, i_x_start} + SPAN_W) > X_MAX_W) ? X_CLAMP : i_x_start;
               w_y         = '0;
               w_dirLeft   = 1'b0;
               w_mode      = i_mode;
               w_colour    = i_colour_in;
               w_cx        = '0;
               w_cy        = '0;
            end
         end
         S_DRAW: begin
            if (i_kill) w_killLatch = 1'b1;
            if (w_accept && w_lastPix) begin
               w_cx        = '0;
               w_cy        = '0;
               w_delayCnt  = '0;
               w_frameCnt  = '0;
               w_stateNext = (r_killLatch || i_kill) ? S_ERASE : S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_kill || r_killLatch) begin
               w_killLatch = 1'b1;
               w_stateNext = S_ERASE;
            end else if (r_delayCnt == LAST_DELAY) begin
               w_delayCnt = '0;
               w_frameCnt = r_frameCnt + FW'(1);
               if ((r_frameCnt + FW'(1)) == FRAME_GOAL) w_stateNext = S_ERASE;
            end else begin
               w_delayCnt = r_delayCnt + DW'(1);
            end
         end
         S_ERASE: begin
            if (w_accept && w_lastPix) begin
               w_cx = '0;
               w_cy = '0;
               if (r_killLatch) begin
                  w_stateNext = S_IDLE;
                  w_killed    = 1'b1;
                  w_killLatch = 1'b0;
               end else begin
                  w_stateNext = S_UPDATE;
               end
            end
         end
         S_UPDATE: begin
            // A blocked zig-zag step spends the move reversing direction with x held.
            if (r_mode) begin
               if (!r_dirLeft) begin
                  if (({2'b00, r_x} + SPAN_W + STEP_X_W) > X_MAX_W) w_dirLeft = 1'b1;
                  else w_x = r_x + STEP_X_B;
               end else begin
                  if ({2'b00, r_x} < STEP_X_W) w_dirLeft = 1'b0;
                  else w_x = r_x - STEP_X_B;
               end
            end
            if (w_yStep > Y_LIMIT_W) begin
               w_stateNext = S_IDLE;
               w_killLatch = 1'b0;
               if (i_kill) w_killed = 1'b1;
               else w_escaped = 1'b1;
            end else begin
               w_y         = w_yStep[6:0];
               w_stateNext = S_DRAW;
               w_killLatch = i_kill;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   assign w_plotNext = (w_stateNext == S_DRAW) || (w_stateNext == S_ERASE);

   // State register; pixel outputs are registered from the next-cycle scan position.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_dirLeft   <= 1'b0;
         r_mode      <= 1'b0;
         r_colour    <= '0;
         r_cx        <= '0;
         r_cy        <= '0;
         r_delayCnt  <= '0;
         r_frameCnt  <= '0;
         r_killLatch <= 1'b0;
         r_xOut      <= '0;
         r_yOut      <= '0;
         r_colourOut <= '0;
         r_plot      <= 1'b0;
         r_active    <= 1'b0;
         r_escaped   <= 1'b0;
         r_killed    <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_x         <= w_x;
         r_y         <= w_y;
         r_dirLeft   <= w_dirLeft;
         r_mode      <= w_mode;
         r_colour    <= w_colour;
         r_cx        <= w_cx;
         r_cy        <= w_cy;
         r_delayCnt  <= w_delayCnt;
         r_frameCnt  <= w_frameCnt;
         r_killLatch <= w_killLatch;
         r_plot      <= w_plotNext;
         r_xOut      <= w_plotNext ? (w_x + {2'b00, w_cx}) : '0;
         r_yOut      <= w_plotNext ? (w_y + {1'b0, w_cy}) : '0;
         r_colourOut <= (w_stateNext == S_DRAW) ? w_colour : '0;
         r_active    <= (w_stateNext != S_IDLE) && (w_stateNext != S_ARM);
         r_escaped   <= w_escaped;
         r_killed    <= w_killed;
      end
   end

   assign o_x_out      = r_xOut;
   assign o_y_out      = r_yOut;
   assign o_colour_out = r_colourOut;
   assign o_plot       = r_plot;
   assign o_active     = r_active;
   assign o_escaped    = r_escaped;
   assign o_killed     = r_killed;

endmodule

// File: tb/tb_enemy_sprite_engine.sv
// Randomized bench for enemy_sprite_engine: accepted pixels, plot run lengths and pulses
// are compared against a per-life model built from sprite position arithmetic.
module tb_enemy_sprite_engine;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int DLY  = 2;
   localparam int FPS  = 3;
   localparam int SX   = 1;
   localparam int SY   = 1;
   localparam int XMAX = 159;
   localparam int YLIM = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       go;
   logic       mode;
   logic [7:0] xStart;
   logic [2:0] colourIn;
   logic       kill;
   logic       pixReady;
   logic [7:0] xOut;
   logic [6:0] yOut;
   logic [2:0] colourOut;
   logic       plot, active, escaped, killed;

   always #5 clk = ~clk;

   enemy_sprite_engine #(
      .SPR_W(W), .SPR_H(H), .DELAY_CYCLES(DLY), .FRAMES_PER_STEP(FPS),
      .STEP_X(SX), .STEP_Y(SY), .X_MAX(XMAX), .Y_LIMIT(YLIM)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_go(go), .i_mode(mode), .i_x_start(xStart),
      .i_colour_in(colourIn), .i_kill(kill), .i_pix_ready(pixReady),
      .o_x_out(xOut), .o_y_out(yOut), .o_colour_out(colourOut), .o_plot(plot),
      .o_active(active), .o_escaped(escaped), .o_killed(killed)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Pixel ready pattern: 0 = always ready, 1 = toggling, 2 = random.
   int readyMode = 0;
   initial begin
      pixReady = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (readyMode)
            0:       pixReady = 1'b1;
            1:       pixReady = ~pixReady;
            default: pixReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: collects accepted pixels, plot run lengths while active, and pulses.
   int gotPix[$];
   int runLvl[$];
   int runLen[$];
   int curLen = 0;
   logic curLvl = 1'b0;
   logic pendValid = 1'b0;
   logic [31:0] pendPix;
   logic prevPlot = 1'b0;
   int escCount, escBad, killCount, killBad, fallCount;

   always @(negedge clk) begin
      if (reset) begin
         pendValid = 1'b0;
         prevPlot  = 1'b0;
         curLen    = 0;
      end else begin
         if (pendValid) begin
            checkOutput("stall_plot", 32'(plot), 32'd1);
            checkOutput("stall_pixel", {14'd0, xOut, yOut, colourOut}, pendPix);
         end
         if (plot && pixReady) begin
            gotPix.push_back(int'({xOut, yOut, colourOut}));
            pendValid = 1'b0;
         end else if (plot) begin
            pendValid = 1'b1;
            pendPix   = {14'd0, xOut, yOut, colourOut};
         end else begin
            pendValid = 1'b0;
         end
         if (escaped) begin
            escCount++;
            if (active || plot) escBad++;
         end
         if (killed) begin
            killCount++;
            if (active || plot) killBad++;
         end
         if (prevPlot && !plot) fallCount++;
         prevPlot = plot;
         if (active) begin
            if (curLen > 0 && plot !== curLvl) begin
               runLvl.push_back(int'(curLvl));
               runLen.push_back(curLen);
               curLen = 0;
            end
            curLvl = plot;
            curLen++;
         end else if (curLen > 0) begin
            runLvl.push_back(int'(curLvl));
            runLen.push_back(curLen);
            curLen = 0;
         end
      end
   end

   // Reference model: the pixel sequence one whole enemy life should produce.
   int expPix[$];
   int expFrames;

   function automatic int pixCode(input int x, input int y, input int c);
      return ((x & 255) << 10) | ((y & 127) << 3) | (c & 7);
   endfunction

   task automatic buildLife(input int xs, input int md, input int col, input int killFrame);
      int x, y, dir;
      expPix.delete();
      expFrames = 0;
      x = (xs + W - 1 > XMAX) ? XMAX - W + 1 : xs;
      y = 0;
      dir = 1;
      for (int f = 0; f < 200; f++) begin
         for (int py = 0; py < H; py++)
            for (int px = 0; px < W; px++) expPix.push_back(pixCode(x + px, y + py, col));
         for (int py = 0; py < H; py++)
            for (int px = 0; px < W; px++) expPix.push_back(pixCode(x + px, y + py, 0));
         expFrames++;
         if (f == killFrame) break;
         if (md != 0) begin
            if (dir > 0) begin
               if (x + W - 1 + SX > XMAX) dir = -1;
               else x = x + SX;
            end else begin
               if (x < SX) dir = 1;
               else x = x - SX;
            end
         end
         if (y + SY > YLIM) break;
         y = y + SY;
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic clearScoreboard();
      gotPix.delete();
      runLvl.delete();
      runLen.delete();
      escCount  = 0;
      escBad    = 0;
      killCount = 0;
      killBad   = 0;
      fallCount = 0;
   endtask

   // Spawn: go high for one cycle, then low; the spawn inputs are scrambled once latched.
   task automatic applyStimulus(input int xs, input int md, input int col);
      @(posedge clk); #1;
      xStart   = 8'(xs);
      mode     = 1'(md);
      colourIn = 3'(col);
      go       = 1'b1;
      tick(1);
      go = 1'b0;
      tick(1);
      xStart   = 8'($urandom);
      mode     = 1'($urandom);
      colourIn = 3'($urandom);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (active !== 1'b0 && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput("idle_within_budget", 32'(n < budget), 32'd1);
      tick(1);
   endtask

   task automatic waitFalls(input int target, input int budget);
      int n = 0;
      while (fallCount < target && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput("plot_fall_within_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic checkLife(input int wantEsc, input int wantKill, input int checkRuns, input int exactRuns);
      int e0;
      checkOutput("pixel_count", 32'(gotPix.size()), 32'(expPix.size()));
      e0 = errors;
      for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
         checkOutput("pixel", 32'(gotPix[i]), 32'(expPix[i]));
         if (errors != e0) break;
      end
      checkOutput("escaped_pulses", 32'(escCount), 32'(wantEsc));
      checkOutput("killed_pulses", 32'(killCount), 32'(wantKill));
      checkOutput("pulse_while_busy", 32'(escBad + killBad), 32'd0);
      checkOutput("end_active", 32'(active), 32'd0);
      checkOutput("end_plot", 32'(plot), 32'd0);
      if (checkRuns != 0) begin
         checkOutput("run_count", 32'(runLen.size()), 32'(4 * expFrames));
         e0 = errors;
         for (int i = 0; i < runLen.size() && i < 4 * expFrames; i++) begin
            if (i % 2 == 0) begin
               checkOutput("run_level_plot", 32'(runLvl[i]), 32'd1);
               if (exactRuns != 0) checkOutput("run_scan_len", 32'(runLen[i]), 32'(W * H));
               else checkOutput("run_scan_min", 32'(runLen[i] >= W * H), 32'd1);
            end else begin
               checkOutput("run_level_gap", 32'(runLvl[i]), 32'd0);
               checkOutput("run_gap_len", 32'(runLen[i]), (i % 4 == 1) ? 32'(DLY * FPS) : 32'd1);
            end
            if (errors != e0) break;
         end
      end
   endtask

   task automatic runLife(input int xs, input int md, input int col, input int rm, input int exact);
      clearScoreboard();
      readyMode = rm;
      buildLife(xs, md, col, -1);
      applyStimulus(xs, md, col);
      checkOutput("first_plot", 32'(plot), 32'd1);
      checkOutput("first_pixel", {14'd0, xOut, yOut, colourOut}, 32'(expPix[0]));
      waitIdle(4000);
      checkLife(1, 0, 1, exact);
   endtask

   task automatic killLife(input int xs, input int md, input int col, input int rm, input int frame, input bit inHold);
      clearScoreboard();
      readyMode = rm;
      buildLife(xs, md, col, frame);
      applyStimulus(xs, md, col);
      waitFalls(inHold ? 2 * frame + 1 : 2 * frame, 2000);
      tick(inHold ? 1 : 3);
      kill = 1'b1;
      tick(1);
      kill = 1'b0;
      checkOutput(inHold ? "kill_hold_erasing" : "kill_draw_plotting", 32'(plot), 32'd1);
      checkOutput(inHold ? "kill_hold_colour" : "kill_draw_colour", 32'(colourOut), inHold ? 32'd0 : 32'(col));
      waitIdle(4000);
      checkLife(0, 1, 0, 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput(tag, {18'd0, xOut, yOut, colourOut, plot, active, escaped, killed}, 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      go       = 1'b0;
      mode     = 1'b0;
      xStart   = '0;
      colourIn = '0;
      kill     = 1'b0;
      clearScoreboard();
      tick(3);
      checkAllZero("reset_outputs");
      @(negedge clk);
      reset = 1'b0;
      tick(2);

      $display("[TB] basic straight descent to escape");
      runLife(14, 0, 7, 0, 1);
      $display("[TB] toggling pixel ready");
      runLife(30, 0, 5, 1, 0);
      $display("[TB] zig-zag near right edge");
      runLife(154, 1, 3, 0, 1);
      $display("[TB] clamped spawn column");
      runLife(200, 0, 6, 0, 1);
      $display("[TB] kill during hold");
      killLife(80, 1, 2, 0, 1, 1'b1);
      $display("[TB] kill during draw");
      killLife(3, 1, 4, 1, 0, 1'b0);

      $display("[TB] reset during erase");
      clearScoreboard();
      readyMode = 0;
      applyStimulus(60, 0, 4);
      waitFalls(1, 200);
      begin
         int n = 0;
         while (plot !== 1'b1 && n < 50) begin
            tick(1);
            n++;
         end
         checkOutput("erase_start_within_budget", 32'(n < 50), 32'd1);
      end
      tick(3);
      #2 reset = 1'b1;
      #1 checkAllZero("reset_mid_erase");
      @(negedge clk);
      reset = 1'b0;
      tick(2);
      runLife(40, 1, 2, 0, 1);

      $display("[TB] random lives");
      for (int k = 0; k < 4; k++)
         runLife(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                 int'($urandom_range(1, 7)), int'($urandom_range(0, 2)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
